// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - signal bundle between the Pong match sequencer and its datapath
//
// Purpose : groups the frame/miss/button inputs and the match-status outputs
//           of pong_game_ctrl so they travel as one port.
// Modports: master - the sequencer (drives play_en .. state)
//           slave  - the surrounding datapath (drives tick, button, misses)
interface pong_game_ctrl_if;
   logic       tick;
   logic       start_button;
   logic       miss_left;
   logic       miss_right;
   logic       play_en;
   logic       ball_reset;
   logic       serve_dir;
   logic [3:0] score_left;
   logic [3:0] score_right;
   logic       point;
   logic       game_over;
   logic       winner;
   logic [2:0] state;

   modport master (
      input  tick, start_button, miss_left, miss_right,
      output play_en, ball_reset, serve_dir, score_left, score_right,
             point, game_over, winner, state
   );

   modport slave (
      output tick, start_button, miss_left, miss_right,
      input  play_en, ball_reset, serve_dir, score_left, score_right,
             point, game_over, winner, state
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong match sequencer: serve/play/point/over FSM with scoring
//
// Purpose : gates paddle movement, holds/releases the ball, keeps both scores
//           and declares the winner. Every output comes from a register.
// Ports   : CLK   - system clock
//           RESET - asynchronous active-high reset
//           bus   - pong_game_ctrl_if.master (tick, start_button, miss_left,
//                   miss_right in; play_en, ball_reset, serve_dir, score_left,
//                   score_right, point, game_over, winner, state out)
module pong_game_ctrl #(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 60,
   parameter int POINT_TICKS = 90
) (
   input  logic              CLK,
   input  logic              RESET,
   pong_game_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);
   localparam logic [7:0] POINT_LAST = 8'(POINT_TICKS - 1);
   localparam logic [3:0] WIN        = 4'(WIN_SCORE);

   // Button synchronizer and falling-edge detector
   logic sync1_q, sync2_q, sync_prev_q, press_q;

   state_t     state_q,       state_d;
   logic [7:0] cnt_q,         cnt_d;
   logic [3:0] score_left_q,  score_left_d;
   logic [3:0] score_right_q, score_right_d;
   logic       serve_dir_q,   serve_dir_d;
   logic       winner_q,      winner_d;
   logic       point_q,       point_d;
   logic       play_en_q,     play_en_d;
   logic       ball_reset_q,  ball_reset_d;
   logic       game_over_q,   game_over_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      score_left_d  = score_left_q;
      score_right_d = score_right_q;
      serve_dir_d   = serve_dir_q;
      winner_d      = winner_q;
      point_d       = 1'b0;

      case (state_q)
         IDLE, OVER: begin
            if (press_q) begin
               state_d       = SERVE;
               score_left_d  = 4'd0;
               score_right_d = 4'd0;
               serve_dir_d   = 1'b0;
            end
         end
         SERVE: begin
            if (bus.tick) begin
               if (cnt_q == SERVE_LAST) state_d = PLAY;
               else                     cnt_d   = cnt_q + 8'd1;
            end
         end
         PLAY: begin
            // A double miss replays the rally without awarding anything
            if (bus.miss_left && bus.miss_right) begin
               state_d = POINT;
            end else if (bus.miss_left) begin
               state_d       = POINT;
               score_right_d = score_right_q + 4'd1;
               serve_dir_d   = 1'b1;
               point_d       = 1'b1;
            end else if (bus.miss_right) begin
               state_d      = POINT;
               score_left_d = score_left_q + 4'd1;
               serve_dir_d  = 1'b0;
               point_d      = 1'b1;
            end
         end
         POINT: begin
            if (bus.tick) begin
               if (cnt_q == POINT_LAST) begin
                  if (score_left_q == WIN) begin
                     state_d  = OVER;
                     winner_d = 1'b0;
                  end else if (score_right_q == WIN) begin
                     state_d  = OVER;
                     winner_d = 1'b1;
                  end else begin
                     state_d = SERVE;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The tick counter measures time within one state only
      if (state_d != state_q) cnt_d = 8'd0;

      // Moore outputs are decoded from the next state and registered
      play_en_d    = (state_d == SERVE) || (state_d == PLAY);
      ball_reset_d = (state_d != PLAY);
      game_over_d  = (state_d == OVER);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         sync_prev_q   <= 1'b1;
         press_q       <= 1'b0;
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         score_left_q  <= 4'd0;
         score_right_q <= 4'd0;
         serve_dir_q   <= 1'b0;
         winner_q      <= 1'b0;
         point_q       <= 1'b0;
         play_en_q     <= 1'b0;
         ball_reset_q  <= 1'b1;
         game_over_q   <= 1'b0;
      end else begin
         sync1_q       <= bus.start_button;
         sync2_q       <= sync1_q;
         sync_prev_q   <= sync2_q;
         press_q       <= sync_prev_q & ~sync2_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         score_left_q  <= score_left_d;
         score_right_q <= score_right_d;
         serve_dir_q   <= serve_dir_d;
         winner_q      <= winner_d;
         point_q       <= point_d;
         play_en_q     <= play_en_d;
         ball_reset_q  <= ball_reset_d;
         game_over_q   <= game_over_d;
      end
   end

   assign bus.play_en     = play_en_q;
   assign bus.ball_reset  = ball_reset_q;
   assign bus.serve_dir   = serve_dir_q;
   assign bus.score_left  = score_left_q;
   assign bus.score_right = score_right_q;
   assign bus.point       = point_q;
   assign bus.game_over   = game_over_q;
   assign bus.winner      = winner_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pong_game_ctrl_if bus_if ();

   pong_game_ctrl #(
      .WIN_SCORE   (7),
      .SERVE_TICKS (3),
      .POINT_TICKS (4)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_tick(input int n);
      for (int i = 0; i < n; i++) begin
         bus_if.tick = 1'b1;
         step();
         bus_if.tick = 1'b0;
      end
   endtask

   task automatic pulse_miss(input logic l, input logic r);
      bus_if.miss_left  = l;
      bus_if.miss_right = r;
      step();
      bus_if.miss_left  = 1'b0;
      bus_if.miss_right = 1'b0;
   endtask

   initial begin
      bus_if.tick         = 1'b0;
      bus_if.start_button = 1'b1;
      bus_if.miss_left    = 1'b0;
      bus_if.miss_right   = 1'b0;

      // Reset values
      step();
      step();
      check("rst_state",      bus_if.state,       8'd0);
      check("rst_ball_reset", bus_if.ball_reset,  8'd1);
      check("rst_play_en",    bus_if.play_en,     8'd0);
      check("rst_score_l",    bus_if.score_left,  8'd0);
      check("rst_score_r",    bus_if.score_right, 8'd0);
      check("rst_game_over",  bus_if.game_over,   8'd0);
      check("rst_point",      bus_if.point,       8'd0);
      rst = 1'b0;
      step();

      // Press: SERVE appears on the 4th edge after the pin falls
      bus_if.start_button = 1'b0;
      step(); step(); step();
      check("press_lat_idle", bus_if.state, 8'd0);
      step();
      check("press_serve",      bus_if.state,      8'd1);
      check("serve_play_en",    bus_if.play_en,    8'd1);
      check("serve_ball_reset", bus_if.ball_reset, 8'd1);
      check("serve_scores",     {bus_if.score_left, bus_if.score_right}, 8'h00);
      for (int i = 0; i < 6; i++) step();
      bus_if.start_button = 1'b1;

      // Misses ignored in SERVE; 2 ticks keep SERVE, 3rd releases the ball
      pulse_miss(1'b1, 1'b0);
      check("serve_miss_ign", bus_if.score_right, 8'd0);
      pulse_tick(2);
      check("serve_2ticks", bus_if.state, 8'd1);
      step();
      pulse_tick(1);
      check("play_state",      bus_if.state,      8'd2);
      check("play_ball_reset", bus_if.ball_reset, 8'd0);

      // Tick in PLAY does nothing; left miss scores for the right player
      pulse_tick(1);
      check("play_tick_ign", bus_if.state, 8'd2);
      pulse_miss(1'b1, 1'b0);
      check("ml_state",     bus_if.state,       8'd3);
      check("ml_score_r",   bus_if.score_right, 8'd1);
      check("ml_serve_dir", bus_if.serve_dir,   8'd1);
      check("ml_point",     bus_if.point,       8'd1);
      check("ml_play_en",   bus_if.play_en,     8'd0);
      step();
      check("ml_point_1cyc", bus_if.point, 8'd0);
      pulse_tick(3);
      check("point_hold", bus_if.state, 8'd3);
      pulse_tick(1);
      check("point_serve", bus_if.state, 8'd1);
      pulse_tick(3);

      // Simultaneous misses: replay, no score, no point pulse
      pulse_miss(1'b1, 1'b1);
      check("dbl_state",     bus_if.state,       8'd3);
      check("dbl_point",     bus_if.point,       8'd0);
      check("dbl_scores",    {bus_if.score_left, bus_if.score_right}, 8'h01);
      check("dbl_serve_dir", bus_if.serve_dir,   8'd1);
      pulse_tick(4);
      pulse_tick(3);

      // Left player reaches 6 points
      for (int i = 0; i < 6; i++) begin
         pulse_miss(1'b0, 1'b1);
         pulse_tick(4);
         pulse_tick(3);
      end
      check("l6_score", bus_if.score_left, 8'd6);
      check("l6_state", bus_if.state,      8'd2);
      check("l6_dir",   bus_if.serve_dir,  8'd0);

      // Winning point
      pulse_miss(1'b0, 1'b1);
      check("win_score", bus_if.score_left, 8'd7);
      check("win_point", bus_if.point,      8'd1);
      pulse_tick(3);
      check("win_hold", bus_if.state, 8'd3);
      pulse_tick(1);
      check("over_state",     bus_if.state,      8'd4);
      check("over_game_over", bus_if.game_over,  8'd1);
      check("over_winner",    bus_if.winner,     8'd0);
      check("over_play_en",   bus_if.play_en,    8'd0);
      check("over_ball_rst",  bus_if.ball_reset, 8'd1);

      // Frozen in OVER
      pulse_miss(1'b1, 1'b0);
      pulse_miss(1'b0, 1'b1);
      pulse_tick(5);
      check("frz_state",  bus_if.state, 8'd4);
      check("frz_scores", {bus_if.score_left, bus_if.score_right}, 8'h71);
      check("frz_winner", bus_if.winner, 8'd0);

      // Restart from OVER
      bus_if.start_button = 1'b0;
      step(); step(); step(); step();
      bus_if.start_button = 1'b1;
      check("rs_state",     bus_if.state,     8'd1);
      check("rs_scores",    {bus_if.score_left, bus_if.score_right}, 8'h00);
      check("rs_game_over", bus_if.game_over, 8'd0);
      check("rs_serve_dir", bus_if.serve_dir, 8'd0);
      pulse_tick(3);
      pulse_miss(1'b1, 1'b0);
      pulse_tick(4);
      pulse_tick(3);
      check("rs_play", bus_if.state, 8'd2);

      // Asynchronous reset mid-PLAY, between clock edges
      #2;
      rst = 1'b1;
      #1;
      check("arst_state",   bus_if.state,       8'd0);
      check("arst_ball",    bus_if.ball_reset,  8'd1);
      check("arst_play_en", bus_if.play_en,     8'd0);
      check("arst_score_r", bus_if.score_right, 8'd0);
      check("arst_dir",     bus_if.serve_dir,   8'd0);
      bus_if.miss_left  = 1'b1;
      bus_if.miss_right = 1'b1;
      step();
      bus_if.miss_left  = 1'b0;
      bus_if.miss_right = 1'b0;
      check("arst_miss_ign", {bus_if.score_left, bus_if.score_right}, 8'h00);
      rst = 1'b0;
      step();
      step();
      check("arst_idle", bus_if.state, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level match sequencer for the Pong datapath. It gates paddle movement, holds and releases the ball, keeps both players' scores, and declares the winner. It sits between the frame-timing logic, the two paddle instances and the ball block. Its outputs are Moore-decoded from registered state, so there is no combinational path from any input to any output.

Parameters:
WIN_SCORE, 7, points needed to win (1..15).
SERVE_TICKS, 60, frame ticks the ball is held before a serve (1..255).
POINT_TICKS, 90, frame ticks of pause after a point (1..255).

Ports:
CLK  input  1  system clock.
RESET  input  1  asynchronous, active-high reset.
tick  input  1  one-cycle pulse, once per video frame.
start_button  input  1  active-low raw push button, asynchronous to CLK.
miss_left  input  1  one-cycle pulse: ball passed the left paddle.
miss_right  input  1  one-cycle pulse: ball passed the right paddle.
play_en  output  1  paddles may move (ANDed with the paddle prescaler enable).
ball_reset  output  1  hold the ball at centre.
serve_dir  output  1  ball direction at the next serve: 0 = rightward, 1 = leftward.
score_left  output  4  left player's score.
score_right  output  4  right player's score.
point  output  1  one-cycle pulse when a point is awarded.
game_over  output  1  match finished.
winner  output  1  0 = left won, 1 = right won; valid while game_over = 1.
state  output  3  IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4.

Behaviour:
- Start button input:
  - start_button passes through a 2-FF synchronizer; both flops reset to 1.
  - A press is a 1 to 0 transition of the synchronized signal and produces a one-cycle internal pulse, press.
  - A press reaches the FSM 3 CLK cycles after the pin falls.
- Reset (asynchronous, RESET = 1), applied at any time including mid-match:
  - state = IDLE, scores = 0, tick counter = 0, serve_dir = 0, winner = 0.
  - point = 0, game_over = 0, play_en = 0, ball_reset = 1.
- Tick counter: 8 bits. It increments only on tick while in SERVE or POINT and clears on every state transition.
- IDLE: play_en = 0, ball_reset = 1. On press: go to SERVE, clear both scores, serve_dir = 0.
- SERVE: play_en = 1, ball_reset = 1. On a tick with counter = SERVE_TICKS-1, go to PLAY. SERVE therefore lasts exactly SERVE_TICKS ticks.
- PLAY: play_en = 1, ball_reset = 0. Events are evaluated every cycle:
  - miss_left only: score_right += 1, serve_dir = 1 (serve goes toward the player who conceded), point = 1 next cycle, go to POINT.
  - miss_right only: score_left += 1, serve_dir = 0, point = 1, go to POINT.
  - miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, point = 0, go to POINT (the rally is replayed).
- POINT: play_en = 0, ball_reset = 1. On a tick with counter = POINT_TICKS-1:
  - If score_left = WIN_SCORE: go to OVER with winner = 0.
  - Else if score_right = WIN_SCORE: go to OVER with winner = 1.
  - Otherwise go to SERVE.
- OVER: game_over = 1, play_en = 0, ball_reset = 1; scores and winner frozen. On press: go to SERVE, clear scores, game_over = 0, serve_dir = 0.
- Ignored inputs:
  - miss_left and miss_right are ignored outside PLAY.
  - press is ignored in SERVE, PLAY and POINT.
  - tick outside SERVE and POINT has no effect.
- Score arithmetic:
  - Scores are 4-bit unsigned and never exceed WIN_SCORE, since no scoring is possible outside PLAY.
  - Wrap at 15 is unreachable; no saturation logic is required.
- Timing:
  - Outputs change on the CLK edge after the causing event.
  - point is registered and asserted for exactly one cycle.
  - state values 5..7 are illegal and fall back to IDLE on the next clock.

Test Plan:
1. Reset, then pull start_button low for 10 cycles -> state = SERVE 4 cycles after the falling edge; scores 0/0; play_en = 1, ball_reset = 1.
2. Stay in SERVE with SERVE_TICKS = 3, apply 3 ticks -> state = PLAY the cycle after the 3rd tick, ball_reset = 0; only 2 ticks -> still SERVE.
3. In PLAY, pulse miss_left -> score_right = 1, serve_dir = 1, point high for 1 cycle, state = POINT; after POINT_TICKS ticks -> SERVE.
4. In PLAY, pulse miss_left and miss_right in the same cycle -> scores unchanged, point = 0, state = POINT.
5. Set score_left = 6 with WIN_SCORE = 7, pulse miss_right -> score_left = 7; after the POINT hold -> state = OVER, game_over = 1, winner = 0; further misses and ticks leave everything unchanged; a press -> SERVE with scores 0/0.
6. Assert RESET asynchronously mid-PLAY, between clock edges -> outputs take their reset values immediately; miss pulses during reset are ignored; after release, state = IDLE.
